// File: rtl/iq_integrator_multi.sv
// Multi-lane I/Q window integrator: sums LANES gated samples per beat over a
// programmable window. Optional macro IQ_INTEG_SAT_EN makes the accumulators clamp instead of wrap.
module iq_integrator_multi #(
   parameter int LANES = 5,
   parameter int DW    = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 11,
   parameter int CNT_W = 14
) (
   input  logic                   clk_100,
   input  logic                   reset,
   input  logic                   start,
   input  logic [LEN_W-1:0]       sample_length,
   input  logic [LANES-1:0]       lane_valid,
   input  logic [LANES*DW-1:0]    data_i_flat,
   input  logic [LANES*DW-1:0]    data_q_flat,
   output logic                   busy,
   output logic                   iq_valid,
   input  logic                   iq_ready,
   output logic [ACC_W-1:0]       i_val,
   output logic [ACC_W-1:0]       q_val,
   output logic [CNT_W-1:0]       sample_count,
   output logic                   overflow,
   output logic                   missed_start
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_INTEGRATE = 2'd1,
      S_HOLD      = 2'd2
   } state_t;

   localparam int POP_W = $clog2(LANES + 1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic [ACC_W-1:0] acc_i_q, acc_i_d;
   logic [ACC_W-1:0] acc_q_q, acc_q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             missed_q, missed_d;

   logic [ACC_W-1:0] lane_sum_i, lane_sum_q;
   logic [POP_W-1:0] pop;
   logic [ACC_W-1:0] base_i, base_q;
   logic [CNT_W-1:0] cnt_base, cnt_next;
   logic [CNT_W:0]   cnt_sum;
   logic [ACC_W:0]   add_i, add_q;

   // Returns {overflow, sum}; overflow = same-sign operands giving a different-sign result.
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      logic             o;
      s = a + b;
      o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef IQ_INTEG_SAT_EN
      if (o) begin
         s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
      return {o, s};
   endfunction

   always_comb begin
      lane_sum_i = '0;
      lane_sum_q = '0;
      pop        = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_valid[k]) begin
            lane_sum_i = lane_sum_i + {{(ACC_W-DW){data_i_flat[k*DW+DW-1]}}, data_i_flat[k*DW +: DW]};
            lane_sum_q = lane_sum_q + {{(ACC_W-DW){data_q_flat[k*DW+DW-1]}}, data_q_flat[k*DW +: DW]};
            pop        = pop + POP_W'(1);
         end
      end
   end

   // Beat 0 is accumulated from IDLE, so the adders start from zero there.
   always_comb begin
      base_i   = (state_q == S_IDLE) ? '0 : acc_i_q;
      base_q   = (state_q == S_IDLE) ? '0 : acc_q_q;
      cnt_base = (state_q == S_IDLE) ? '0 : cnt_q;
      add_i    = acc_add(base_i, lane_sum_i);
      add_q    = acc_add(base_q, lane_sum_q);
      cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(pop);
      cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      beat_d   = beat_q;
      acc_i_d  = acc_i_q;
      acc_q_d  = acc_q_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      missed_d = start && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d = sample_length;
               if (sample_length == '0) begin
                  acc_i_d = '0;
                  acc_q_d = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  beat_d  = '0;
                  state_d = S_HOLD;
               end else begin
                  acc_i_d = add_i[ACC_W-1:0];
                  acc_q_d = add_q[ACC_W-1:0];
                  cnt_d   = cnt_next;
                  ovf_d   = add_i[ACC_W] | add_q[ACC_W];
                  beat_d  = LEN_W'(1);
                  state_d = (sample_length == LEN_W'(1)) ? S_HOLD : S_INTEGRATE;
               end
            end
         end
         S_INTEGRATE: begin
            acc_i_d = add_i[ACC_W-1:0];
            acc_q_d = add_q[ACC_W-1:0];
            cnt_d   = cnt_next;
            ovf_d   = ovf_q | add_i[ACC_W] | add_q[ACC_W];
            if (beat_q == len_q - LEN_W'(1)) begin
               state_d = S_HOLD;
            end else begin
               beat_d = beat_q + LEN_W'(1);
            end
         end
         S_HOLD: begin
            if (iq_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            len_d    = '0;
            beat_d   = '0;
            acc_i_d  = '0;
            acc_q_d  = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            missed_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         beat_q   <= '0;
         acc_i_q  <= '0;
         acc_q_q  <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         acc_i_q  <= acc_i_d;
         acc_q_q  <= acc_q_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         missed_q <= missed_d;
      end
   end

   assign busy         = (state_q == S_INTEGRATE);
   assign iq_valid     = (state_q == S_HOLD);
   assign i_val        = acc_i_q;
   assign q_val        = acc_q_q;
   assign sample_count = cnt_q;
   assign overflow     = ovf_q;
   assign missed_start = missed_q;

endmodule

// File: tb/tb_iq_integrator_multi.sv
// Bench for iq_integrator_multi: windows of random/directed lane data, an
// arithmetic reference model feeding an expected queue, and a result monitor.
module tb_iq_integrator_multi;

   localparam int LANES = 5;
   localparam int DW    = 16;
   localparam int ACC_W = 20;
   localparam int LEN_W = 11;
   localparam int CNT_W = 6;
   localparam longint ACC_MAX = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint ACC_MIN = -(longint'(1) << (ACC_W-1));
   localparam longint ACC_MOD = longint'(1) << ACC_W;
   localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

   typedef struct {
      longint i;
      longint q;
      longint cnt;
      bit     ovf;
      int     vcyc;
   } exp_t;

   logic                clk_100 = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [LEN_W-1:0]    sample_length = '0;
   logic [LANES-1:0]    lane_valid = '0;
   logic [LANES*DW-1:0] data_i_flat = '0;
   logic [LANES*DW-1:0] data_q_flat = '0;
   logic                iq_ready = 1'b0;
   logic                busy, iq_valid, overflow, missed_start;
   logic [ACC_W-1:0]    i_val, q_val;
   logic [CNT_W-1:0]    sample_count;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   exp_missed = 0;
   int   got_missed = 0;
   bit   prev_v = 1'b0;

   // model state and directed-stimulus settings
   longint m_i, m_q, m_cnt;
   bit     m_ovf;
   int     mode = 0;
   logic [DW-1:0]    c_i, c_q;
   logic [LANES-1:0] c_lv;

   iq_integrator_multi #(
      .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
   ) dut (
      .clk_100(clk_100), .reset(reset), .start(start), .sample_length(sample_length),
      .lane_valid(lane_valid), .data_i_flat(data_i_flat), .data_q_flat(data_q_flat),
      .busy(busy), .iq_valid(iq_valid), .iq_ready(iq_ready), .i_val(i_val),
      .q_val(q_val), .sample_count(sample_count), .overflow(overflow),
      .missed_start(missed_start)
   );

   // clock / cycle counter
   always #5 clk_100 = ~clk_100;
   always @(posedge clk_100) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   // signed add at ACC_W bits: flag overflow, then clamp or wrap
   function automatic longint acc_step(input longint a, input longint b);
      longint s;
      s = a + b;
      if (s > ACC_MAX || s < ACC_MIN) begin
         m_ovf = 1'b1;
`ifdef IQ_INTEG_SAT_EN
         s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
         s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
`endif
      end
      return s;
   endfunction

   task automatic model_beat();
      longint si, sq;
      int     pop;
      si = 0; sq = 0; pop = 0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_valid[k]) begin
            si += longint'($signed(data_i_flat[k*DW +: DW]));
            sq += longint'($signed(data_q_flat[k*DW +: DW]));
            pop++;
         end
      end
      m_i = acc_step(m_i, si);
      m_q = acc_step(m_q, sq);
      m_cnt = m_cnt + pop;
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
   endtask

   task automatic set_data();
      logic [DW-1:0] vi, vq;
      for (int k = 0; k < LANES; k++) begin
         case (mode)
            0: begin vi = DW'($urandom); vq = DW'($urandom); end
            1: begin vi = c_i; vq = c_q; end
            default: begin
               vi = ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000;
               vq = ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000;
            end
         endcase
         data_i_flat[k*DW +: DW] = vi;
         data_q_flat[k*DW +: DW] = vq;
      end
      lane_valid = (mode == 1) ? c_lv : LANES'($urandom);
   endtask

   // driver: one full window including hold/backpressure and handshake
   task automatic run_window(input int len, input int wait_ready, input bit miss_int,
                             input bit miss_hold, input bit miss_with_hs);
      int   c, nb;
      exp_t e;
      start = 1'b1;
      sample_length = LEN_W'(len);
      c = cyc;
      m_i = 0; m_q = 0; m_cnt = 0; m_ovf = 1'b0;
      set_data();
      iq_ready = 1'($urandom_range(0, 1));
      if (len != 0) model_beat();
      nb = (len == 0) ? 1 : len;
      for (int b = 1; b < nb; b++) begin
         tick();
         if (b == 1) chk("busy_integrate", busy, 1);
         start = miss_int && (b == 1);
         if (start) exp_missed++;
         sample_length = LEN_W'($urandom);
         set_data();
         iq_ready = 1'($urandom_range(0, 1));
         model_beat();
      end
      e.i = m_i; e.q = m_q; e.cnt = m_cnt; e.ovf = m_ovf; e.vcyc = c + nb;
      exp_q.push_back(e);
      tick();
      chk("busy_hold", busy, 0);
      for (int w = 0; w < wait_ready; w++) begin
         start = miss_hold && (w == 0);
         if (start) exp_missed++;
         iq_ready = 1'b0;
         set_data();
         tick();
      end
      start = miss_with_hs;
      if (start) exp_missed++;
      iq_ready = 1'b1;
      set_data();
      tick();
      start = 1'b0;
      iq_ready = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_iq_valid"}, iq_valid, 0);
      chk({tag, "_i_val"}, i_val, 0);
      chk({tag, "_q_val"}, q_val, 0);
      chk({tag, "_count"}, sample_count, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_missed"}, missed_start, 0);
   endtask

   // monitor: compare every HOLD cycle against the head of the expected queue
   always @(negedge clk_100) begin
      if (missed_start) got_missed++;
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (iq_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", iq_valid, 0);
            end else begin
               if (!prev_v) chk("valid_latency", cyc, exp_q[0].vcyc);
               chk("i_val", longint'($signed(i_val)), exp_q[0].i);
               chk("q_val", longint'($signed(q_val)), exp_q[0].q);
               chk("sample_count", sample_count, exp_q[0].cnt);
               chk("overflow", overflow, exp_q[0].ovf);
               if (iq_ready) void'(exp_q.pop_front());
            end
         end
         prev_v = iq_valid && !iq_ready;
      end
   end

   initial begin
      repeat (3) tick();
      check_cleared("reset");
      reset = 1'b0;
      tick();

      // basic sum
      mode = 1; c_i = DW'(100); c_q = DW'(-50); c_lv = '1;
      run_window(4, 0, 1'b0, 1'b0, 1'b0);
      // lane gating with backpressure and ignored starts
      c_i = DW'(10); c_q = DW'(10); c_lv = 5'b10101;
      run_window(3, 5, 1'b1, 1'b1, 1'b0);
      // zero-length window; start coincident with handshake
      run_window(0, 2, 1'b0, 1'b0, 1'b1);
      tick();
      run_window(1, 1, 1'b0, 1'b0, 1'b0);
      // full-scale overflow on both accumulators
      c_i = 16'h7fff; c_q = 16'h8000; c_lv = '1;
      run_window(8, 1, 1'b1, 1'b0, 1'b0);
      // sample_count saturation
      c_i = DW'(1); c_q = DW'(-1);
      run_window(20, 0, 1'b0, 1'b0, 1'b0);

      // reset at beat 2 of a 10-beat window
      mode = 0;
      start = 1'b1; sample_length = LEN_W'(10); set_data();
      tick();
      start = 1'b0; set_data();
      tick();
      reset = 1'b1; set_data();
      tick();
      reset = 1'b0;
      check_cleared("mid_reset");
      mode = 1; c_i = DW'(100); c_q = DW'(-50); c_lv = '1;
      run_window(4, 0, 1'b0, 1'b0, 1'b0);

      // randomized windows
      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 2);
         if (mode == 1) mode = 0;
         run_window($urandom_range(0, 14), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) tick();
      end

      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);
      chk("missed_start_count", got_missed, exp_missed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end of run, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iq_integrator_multi.md
Name: iq_integrator_multi

Overview:
- Parametrised successor to the single-purpose IQ integrator.
- Accumulates LANES parallel rotated I/Q samples per clk_100 cycle over a programmable window of sample_length beats. Only lanes flagged valid by the sampler are counted.
- Presents the sums and a valid-sample count through a valid/ready output handshake.
- Sits between the rotation multiplier and the binning/classifier stage.

Parameters:
- LANES, 5, samples delivered per clock.
- DW, 16, signed width of each rotated I/Q sample.
- ACC_W, 32, signed accumulator width; ACC_W >= DW + 3.
- LEN_W, 11, width of sample_length (window in beats).
- CNT_W, 14, width of sample_count.

Ports:
- clk_100  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; the first window beat is in the same cycle.
- sample_length  in  LEN_W  window length in beats; latched on accepted start.
- lane_valid  in  LANES  per-lane sample-valid (non-zero phase); bit k gates lane k.
- data_i_flat  in  LANES*DW  signed I samples, lane k at bits [k*DW +: DW].
- data_q_flat  in  LANES*DW  signed Q samples, same packing.
- busy  out  1  high in INTEGRATE.
- iq_valid  out  1  result available.
- iq_ready  in  1  downstream accepts the result.
- i_val  out  ACC_W  signed I sum.
- q_val  out  ACC_W  signed Q sum.
- sample_count  out  CNT_W  number of lane samples accumulated.
- overflow  out  1  accumulator overflowed during this window.
- missed_start  out  1  one-cycle pulse when start arrives while not IDLE.

Behaviour:
- Reset is synchronous and active-high on clk_100. On reset: state IDLE; busy, iq_valid, missed_start and overflow = 0; i_val, q_val and sample_count = 0. Reset wins over every other input, including mid-window and mid-handshake.
- States:
  - IDLE: waits for start.
  - INTEGRATE: accumulates beats.
  - HOLD: holds the result until handshake.
  - Any other encoding goes to IDLE with outputs cleared.
- IDLE, start=1:
  - Latch sample_length into len_q.
  - Clear the accumulators, beat counter, sample_count and overflow.
  - If len_q = 0: go to HOLD with zero results; no data accumulated.
  - Otherwise: accumulate this cycle's data as beat 0, beat counter = 1, go to INTEGRATE.
- Per beat:
  - lane_sum_i = sum over k of (lane_valid[k] ? sext(lane_i[k]) : 0), computed at ACC_W; same for Q.
  - sample_count += popcount(lane_valid).
  - All arithmetic is signed two's complement. Lane sum and accumulate occur in the same cycle; no pipeline in the accumulate path.
- INTEGRATE, each cycle:
  - Accumulate the beat.
  - If beat counter = len_q - 1, this is the final beat: go to HOLD next cycle.
  - Otherwise increment the beat counter.
  - A window of N beats covers exactly N consecutive cycles starting at the start cycle.
- HOLD:
  - iq_valid = 1; i_val, q_val, sample_count and overflow held stable.
  - When iq_valid & iq_ready: go to IDLE and drop iq_valid the next cycle.
  - iq_ready while not HOLD is ignored.
- Latency: iq_valid rises on the cycle after the final beat, i.e. start cycle + len_q. For len_q = 0 it rises on the cycle after start.
- start while INTEGRATE or HOLD: ignored; latched window unchanged; missed_start pulses high for one cycle.
- start and handshake in the same HOLD cycle: the start is not accepted; missed_start pulses. Acceptance requires IDLE.
- sample_length changes after an accepted start have no effect on the current window.
- Overflow: set sticky when signed overflow occurs in an accumulator add (operands same sign, result sign differs), in either I or Q. Cleared only on accepted start or reset. Without the optional feature the accumulator wraps modulo 2^ACC_W.
- sample_count saturates at 2^CNT_W - 1. It never wraps.

Optional Feature:
- Macro: IQ_INTEG_SAT_EN.
- Defined: on signed overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1). It then continues accumulating from the clamped value. overflow is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W; overflow flag behaviour is identical.

Test Plan:
- Basic sum: LANES=5, sample_length=4, all lane_valid=1, every I=100, Q=-50 for 4 cycles from start. Expect iq_valid at start+4 with i_val=2000, q_val=-1000, sample_count=20, overflow=0.
- Lane gating: lane_valid=5'b10101, I=10 on all lanes, sample_length=3. Expect i_val=90, sample_count=9.
- Handshake and backpressure: hold iq_ready=0 for 5 cycles after iq_valid. Expect outputs stable and iq_valid high throughout. Assert iq_ready=1: iq_valid low the next cycle and state IDLE.
- Ignored start: pulse start during INTEGRATE and again during HOLD. Expect missed_start pulse each time and the result unchanged. A start after return to IDLE is accepted.
- Overflow: ACC_W=20, I=32767 on all 5 lanes, sample_length=8. Expect overflow=1. With IQ_INTEG_SAT_EN, i_val=524287; without it, i_val = the 20-bit wrapped value of 1310680 (= 262104). Also sample_length=0 yields iq_valid at start+1 with all sums 0.
- Reset mid-window: assert reset at beat 2 of a 10-beat window. Expect busy=0 and all outputs 0 next cycle; a new start produces a correct, uncontaminated sum.
